// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package pc_fetch_sequencer_pkg;

    localparam int          INSTR_W              = 32;
    localparam int          PC_STEP              = 4;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HOLD = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Fetch bundle: instruction-memory request/response, decode handshake,
// redirect input and PC status. master = sequencer, slave = environment.
interface pc_fetch_sequencer_if
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32
);
    logic               imem_req;
    logic [XLEN-1:0]    imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    instr_pc;
    logic               instr_ready;

    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_target;

    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    PCPlus4;
    logic               misalign_err;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_target,
        output pc, PCPlus4, misalign_err
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_target,
        input  pc, PCPlus4, misalign_err
    );

endinterface

// File: rtl/pc_fetch_sequencer_pc_plus_4.sv
// PC incrementer: next sequential PC, wrapping modulo 2^XLEN.
module PC_Plus_4
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] pc_plus_4
);

    assign pc_plus_4 = pc_in + XLEN'(PC_STEP);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and single-outstanding instruction fetch sequencer.
//
// state | meaning
// IDLE  | first cycle after reset release, no request
// REQ   | imem_req high at pc, waiting for imem_gnt
// WAIT  | request granted, waiting for imem_rvalid
// DROP  | a killed request is still in flight; swallow its response
// HOLD  | word buffered, instr_valid high until decode takes it
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.master bus
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] REQ  = ST_REQ;
    localparam logic [2:0] WAIT = ST_WAIT;
    localparam logic [2:0] DROP = ST_DROP;
    localparam logic [2:0] HOLD = ST_HOLD;

    logic [2:0]         state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [XLEN-1:0]    instr_pc_q, instr_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               misalign_q, misalign_d;

    logic [XLEN-1:0]    pc_plus_4;
    logic [XLEN-1:0]    redirect_pc;
    logic               redirect_act;

    PC_Plus_4 #(.XLEN(XLEN)) u_pc_plus_4 (
        .pc_in     (pc_q),
        .pc_plus_4 (pc_plus_4)
    );

    assign redirect_pc  = {bus.redirect_target[XLEN-1:2], 2'b00};
    assign redirect_act = bus.redirect_valid && (state_q != IDLE);

    // Next-state, PC and output-buffer update; redirect outranks everything.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        misalign_d    = misalign_q;

        if (redirect_act) begin
            pc_d = redirect_pc;
            if (bus.redirect_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (bus.imem_gnt) begin
                    // A grant alongside a redirect leaves the old-address request in flight.
                    state_d = redirect_act ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (redirect_act) begin
                    state_d = bus.imem_rvalid ? REQ : DROP;
                end else if (bus.imem_rvalid) begin
                    instr_d       = bus.imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_plus_4;
                    state_d       = HOLD;
                end
            end
            DROP: begin
                // Leave once the stale response is back, even if a further
                // redirect lands in the same cycle: nothing else is outstanding.
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_act || bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            misalign_q    <= misalign_d;
        end
    end

    assign bus.imem_req     = (state_q == REQ);
    assign bus.imem_addr    = pc_q;
    assign bus.instr_valid  = instr_valid_q;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign bus.pc           = pc_q;
    assign bus.PCPlus4      = pc_plus_4;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: memory responder model,
// decode-side scoreboard, hand sequences and a table of redirect vectors.
module tb_pc_fetch_sequencer;
    import pc_fetch_sequencer_pkg::*;

    logic clk;
    logic rst_n;

    pc_fetch_sequencer_if #(.XLEN(32)) bus ();

    pc_fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    typedef struct {
        logic [31:0] tgt;
        logic [31:0] held_pc;
        bit          hs;
        int          lat;
        logic [31:0] addr;
        logic [31:0] nxt;
        bit          mis;
    } vec_t;

    exp_t        exp_q[$];
    logic [31:0] grant_log[$];
    vec_t        vecs[5];

    int checks = 0;
    int errors = 0;

    int          lat;
    bit          pend;
    int          pend_wait;
    logic [31:0] pend_addr;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'h0050_0093 ^ (a << 8);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: sample pre-edge handshakes/grants, then update the memory model.
    task automatic cycle();
        logic        g, hs;
        logic [31:0] ga, hs_pc, hs_word;
        exp_t        e;
        g       = bus.imem_req && bus.imem_gnt;
        ga      = bus.imem_addr;
        hs      = bus.instr_valid && bus.instr_ready;
        hs_pc   = bus.instr_pc;
        hs_word = bus.instr;
        @(posedge clk);
        #1;
        if (hs) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_handshake: got pc %h expected none", hs_pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_instr_pc", hs_pc, e.pc);
                chk("sb_instr", hs_word, e.word);
            end
        end
        if (g) begin
            grant_log.push_back(ga);
            pend      = 1'b1;
            pend_addr = ga;
            pend_wait = lat - 1;
        end
        bus.imem_rvalid = 1'b0;
        if (pend) begin
            if (pend_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = word_of(pend_addr);
                pend            = 1'b0;
            end else begin
                pend_wait--;
            end
        end
    endtask

    task automatic wait_q_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic wait_sig(input string name, input bit want_valid);
        int n = 0;
        while (((want_valid ? bus.instr_valid : bus.imem_req) !== 1'b1) && n < 60) begin
            cycle();
            n++;
        end
        chk({name, "_timeout"}, 32'(n < 60), 32'd1);
    endtask

    task automatic push_exp(input logic [31:0] a);
        exp_t e;
        e.pc   = a;
        e.word = word_of(a);
        exp_q.push_back(e);
    endtask

    initial begin
        vecs[0] = '{tgt: 32'h0000_1000, held_pc: 32'h0000_0304, hs: 1'b1, lat: 1,
                    addr: 32'h0000_1000, nxt: 32'h0000_1004, mis: 1'b0};
        vecs[1] = '{tgt: 32'h0000_2008, held_pc: 32'h0000_1004, hs: 1'b0, lat: 2,
                    addr: 32'h0000_2008, nxt: 32'h0000_200C, mis: 1'b0};
        vecs[2] = '{tgt: 32'h0000_0203, held_pc: 32'h0000_200C, hs: 1'b1, lat: 1,
                    addr: 32'h0000_0200, nxt: 32'h0000_0204, mis: 1'b1};
        vecs[3] = '{tgt: 32'h0000_4001, held_pc: 32'h0000_0204, hs: 1'b0, lat: 3,
                    addr: 32'h0000_4000, nxt: 32'h0000_4004, mis: 1'b1};
        vecs[4] = '{tgt: 32'hFFFF_FFFC, held_pc: 32'h0000_4004, hs: 1'b0, lat: 1,
                    addr: 32'hFFFF_FFFC, nxt: 32'h0000_0000, mis: 1'b1};

        rst_n               = 1'b0;
        bus.imem_gnt        = 1'b0;
        bus.imem_rvalid     = 1'b0;
        bus.imem_rdata      = '0;
        bus.instr_ready     = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        lat                 = 1;
        pend                = 1'b0;
        pend_wait           = 0;
        pend_addr           = '0;

        // Reset state
        repeat (2) cycle();
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        rst_n = 1'b1;
        chk("idle_no_req", 32'(bus.imem_req), 32'd0);
        cycle();
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0);
        chk("first_pcplus4", bus.PCPlus4, 32'h4);

        // Straight-line fetch of address 0
        bus.imem_gnt    = 1'b1;
        bus.instr_ready = 1'b1;
        push_exp(32'h0);
        wait_q_empty("fetch0");
        bus.instr_ready = 1'b0;
        chk("pc_after_fetch0", bus.pc, 32'h4);

        // Backpressure on the word at 4
        wait_sig("bp_valid", 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(bus.instr_valid), 32'd1);
            chk("bp_instr", bus.instr, word_of(32'h4));
            chk("bp_instr_pc", bus.instr_pc, 32'h4);
            chk("bp_no_req", 32'(bus.imem_req), 32'd0);
            cycle();
        end
        push_exp(32'h4);
        bus.instr_ready = 1'b1;
        wait_q_empty("bp_release");
        chk("next_req_after_bp", 32'(bus.imem_req), 32'd1);
        chk("next_addr_after_bp", bus.imem_addr, 32'h8);

        // Redirect while the request for 0x8 is outstanding
        lat = 3;
        cycle();
        chk("grant_count", 32'(grant_log.size()), 32'd3);
        chk("grant0", grant_log[0], 32'h0);
        chk("grant1", grant_log[1], 32'h4);
        chk("grant2", grant_log[2], 32'h8);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0100;
        cycle();
        bus.redirect_valid = 1'b0;
        lat = 1;
        chk("wait_redir_req_low", 32'(bus.imem_req), 32'd0);
        push_exp(32'h100);
        wait_sig("wait_redir_req", 1'b0);
        chk("wait_redir_addr", bus.imem_addr, 32'h100);
        chk("wait_redir_no_valid", 32'(bus.instr_valid), 32'd0);
        wait_q_empty("wait_redir");
        bus.instr_ready = 1'b0;

        // Redirect coinciding with a grant in REQ
        chk("gnt_redir_in_req", 32'(bus.imem_req), 32'd1);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0300;
        cycle();
        bus.redirect_valid = 1'b0;
        chk("drop_req_low", 32'(bus.imem_req), 32'd0);
        chk("drop_stale_rvalid", 32'(bus.imem_rvalid), 32'd1);
        cycle();
        chk("drop_then_req", 32'(bus.imem_req), 32'd1);
        chk("drop_then_addr", bus.imem_addr, 32'h300);
        chk("drop_no_valid", 32'(bus.instr_valid), 32'd0);
        push_exp(32'h300);
        bus.instr_ready = 1'b1;
        wait_q_empty("gnt_redir");
        bus.instr_ready = 1'b0;

        // Table of redirects taken from HOLD
        for (int v = 0; v < 5; v++) begin
            wait_sig("vec_hold", 1'b1);
            chk("vec_held_pc", bus.instr_pc, vecs[v].held_pc);
            if (vecs[v].hs) begin
                push_exp(vecs[v].held_pc);
                bus.instr_ready = 1'b1;
            end
            bus.redirect_valid  = 1'b1;
            bus.redirect_target = vecs[v].tgt;
            cycle();
            bus.redirect_valid = 1'b0;
            bus.instr_ready    = 1'b0;
            chk("vec_hs_drained", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            chk("vec_valid_cleared", 32'(bus.instr_valid), 32'd0);
            chk("vec_req", 32'(bus.imem_req), 32'd1);
            chk("vec_addr", bus.imem_addr, vecs[v].addr);
            chk("vec_pc", bus.pc, vecs[v].addr);
            chk("vec_misalign", 32'(bus.misalign_err), 32'(vecs[v].mis));
            lat = vecs[v].lat;
            push_exp(vecs[v].addr);
            bus.instr_ready = 1'b1;
            wait_q_empty("vec_fetch");
            bus.instr_ready = 1'b0;
            chk("vec_next_pc", bus.pc, vecs[v].nxt);
            chk("vec_next_pcplus4", bus.PCPlus4, vecs[v].nxt + 32'd4);
        end

        // Wrap landed on 0; hold the fetch in WAIT and reset asynchronously
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        lat = 3;
        cycle();
        chk("wait_before_reset", 32'(bus.imem_req), 32'd0);
        chk("misalign_sticky", 32'(bus.misalign_err), 32'd1);
        #2;
        rst_n        = 1'b0;
        bus.imem_gnt = 1'b0;
        pend         = 1'b0;
        #1;
        chk("areset_imem_req", 32'(bus.imem_req), 32'd0);
        chk("areset_imem_addr", bus.imem_addr, 32'h0);
        chk("areset_pc", bus.pc, 32'h0);
        chk("areset_pcplus4", bus.PCPlus4, 32'h4);
        chk("areset_instr_valid", 32'(bus.instr_valid), 32'd0);
        chk("areset_instr", bus.instr, 32'h0);
        chk("areset_instr_pc", bus.instr_pc, 32'h0);
        chk("areset_misalign", 32'(bus.misalign_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
